sram_busctl: RTL and testbench

Parametrised external SRAM bus controller for the p601zero SoC. It replaces the ad-hoc extbus state machine and the VPU override muxing with one arbitrated sequencer. It serves the 6801 core and up to DMA_CH video/DMA requesters, applies the paged-memory window translation, and generates cycle-accurate SRAM strobes with programmable wait states. It sits between the CPU address decode (en_ext && vma) and the EXT_AD/EXT_DQ/EXT_WE_n/EXT_OE_n/SRAM_CS2 pins.

---
 rtl/busctl_pkg.sv | 35 +++
 rtl/busctl_arb.sv | 102 ++++++++++
 rtl/sram_busctl.sv | 225 ++++++++++++++++++++++
 tb/tb_sram_busctl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/busctl_pkg.sv
// busctl_pkg: shared encodings and constants for the external SRAM bus controller.
//   - FSM state encoding
//   - owner encoding (DMA channels 0..3, CPU as a separate code)
//   - paged-window constants and the round-robin pointer helper
package busctl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Owner codes 0..3 are DMA channels; the CPU sits above the largest channel index.
  localparam int                 OWNER_W   = 3;
  localparam logic [OWNER_W-1:0] OWNER_CPU = 3'd4;

  // Round-robin pointer covers up to four DMA channels.
  localparam int PTR_W = 2;

  // CPU addresses 0b110x_xxxx_xxxx_xxxx fall in the paged window.
  localparam logic [2:0] PAGE_WIN_BASE = 3'b110;
  localparam int         PAGE_OFS_W    = 13;

  // Channel that follows `owner` in round-robin order, wrapping at n_ch.
  function automatic logic [PTR_W-1:0] rr_next(input logic [OWNER_W-1:0] owner,
                                               input int                 n_ch);
    if ((int'(owner) + 1) >= n_ch) begin
      return '0;
    end else begin
      return PTR_W'(int'(owner) + 1);
    end
  endfunction

endpackage

// File: rtl/busctl_arb.sv
// busctl_arb: picks the owner of the next SRAM access slot.
//   DMA beats the CPU unless the CPU already lost one slot to DMA (starvation flag).
//   Optional macro SRAM_BUSCTL_RR_EN: DMA channels served round-robin; otherwise
//   fixed priority with channel 0 highest.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   dma_req          per-channel DMA read request (level)
//   cpu_pend         CPU request still waiting for service
//   take             the controller latches the current grant this cycle
//   dma_done/done_owner (RR build only) a DMA access is in DONE, and its channel
//   gnt_valid        some requester is pending
//   gnt_owner        owner code of the winner
module busctl_arb
  import busctl_pkg::*;
#(
  parameter int DMA_CH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DMA_CH-1:0]  dma_req,
  input  logic               cpu_pend,
  input  logic               take,
`ifdef SRAM_BUSCTL_RR_EN
  input  logic               dma_done,
  input  logic [OWNER_W-1:0] done_owner,
`endif
  output logic               gnt_valid,
  output logic [OWNER_W-1:0] gnt_owner
);

  logic               starve_q, starve_d;
  logic               dma_any;
  logic [OWNER_W-1:0] dma_pick;
`ifdef SRAM_BUSCTL_RR_EN
  logic [PTR_W-1:0]   ptr_q, ptr_d, ptr_eff;
  logic               found;
`endif

  // Grant selection plus next-state of the starvation flag and pointer.
  always_comb begin
    dma_any  = |dma_req;
    dma_pick = '0;
`ifdef SRAM_BUSCTL_RR_EN
    // A back-to-back grant in DONE must already see the advanced pointer.
    if (dma_done) begin
      ptr_eff = rr_next(done_owner, DMA_CH);
      ptr_d   = ptr_eff;
    end else begin
      ptr_eff = ptr_q;
      ptr_d   = ptr_q;
    end
    found = 1'b0;
    for (int k = 0; k < DMA_CH; k++) begin
      if (!found && dma_req[(int'(ptr_eff) + k) % DMA_CH]) begin
        dma_pick = OWNER_W'((int'(ptr_eff) + k) % DMA_CH);
        found    = 1'b1;
      end else begin
        dma_pick = dma_pick;
      end
    end
`else
    // Scan downwards so the lowest requesting channel is the last to write.
    for (int i = DMA_CH - 1; i >= 0; i--) begin
      if (dma_req[i]) begin
        dma_pick = OWNER_W'(i);
      end else begin
        dma_pick = dma_pick;
      end
    end
`endif

    gnt_valid = dma_any | cpu_pend;
    if (cpu_pend && (starve_q || !dma_any)) begin
      gnt_owner = OWNER_CPU;
    end else begin
      gnt_owner = dma_pick;
    end

    // CPU passed over by a DMA grant wins the following slot.
    if (take) begin
      starve_d = (gnt_owner != OWNER_CPU) && cpu_pend;
    end else begin
      starve_d = starve_q;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= 1'b0;
`ifdef SRAM_BUSCTL_RR_EN
      ptr_q    <= '0;
`endif
    end else begin
      starve_q <= starve_d;
`ifdef SRAM_BUSCTL_RR_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

endmodule

// File: rtl/sram_busctl.sv
// sram_busctl: arbitrated external SRAM sequencer for the CPU and DMA_CH read-only
// DMA requesters, with paged-window translation for CPU addresses.
// Access: SETUP (1) -> STROBE (WAIT_STATES+1) -> DONE (1); DONE chains straight into
// SETUP when another request is pending. All outputs registered except cpu_hold.
// Optional macro SRAM_BUSCTL_RR_EN: round-robin DMA channel order (see busctl_arb).
// Ports:
//   cpu_req/cpu_rw/cpu_addr/cpu_wdata  CPU access request (rw 1 = read)
//   cpu_rdata, cpu_hold                CPU read data (valid in DONE), core stall
//   page_en/page_wp/page_sel           paged-window control
//   dma_req/dma_addr                   DMA read requests, packed addresses
//   dma_ack/dma_rdata                  DONE pulse per channel, read data
//   ext_*                              SRAM pins
module sram_busctl
  import busctl_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int EXT_AW      = 17,
  parameter int DMA_CH      = 2,
  parameter int WAIT_STATES = 2,
  parameter int PAGE_BITS   = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_req,
  input  logic                     cpu_rw,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic [7:0]               cpu_wdata,
  output logic [7:0]               cpu_rdata,
  output logic                     cpu_hold,
  input  logic                     page_en,
  input  logic                     page_wp,
  input  logic [PAGE_BITS-1:0]     page_sel,
  input  logic [DMA_CH-1:0]        dma_req,
  input  logic [DMA_CH*EXT_AW-1:0] dma_addr,
  output logic [DMA_CH-1:0]        dma_ack,
  output logic [7:0]               dma_rdata,
  output logic [EXT_AW-1:0]        ext_ad,
  input  logic [7:0]               ext_dq_i,
  output logic [7:0]               ext_dq_o,
  output logic                     ext_dq_oe,
  output logic                     ext_cs,
  output logic                     ext_we_n,
  output logic                     ext_oe_n
);

  state_e             state_q, state_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic               rw_q, rw_d;
  logic [2:0]         wait_q, wait_d;
  logic [EXT_AW-1:0]  ext_ad_q, ext_ad_d;
  logic [7:0]         ext_dq_o_q, ext_dq_o_d;
  logic               ext_dq_oe_q, ext_dq_oe_d;
  logic               ext_cs_q, ext_cs_d;
  logic               ext_we_n_q, ext_we_n_d;
  logic               ext_oe_n_q, ext_oe_n_d;
  logic [7:0]         cpu_rdata_q, cpu_rdata_d;
  logic [7:0]         dma_rdata_q, dma_rdata_d;
  logic [DMA_CH-1:0]  dma_ack_q, dma_ack_d;

  logic               gnt_valid, take, cpu_paged, launch_rw;
  logic [OWNER_W-1:0] gnt_owner;
  logic [EXT_AW-1:0]  cpu_ext_ad, dma_ext_ad, launch_ad;

  // The CPU access finishing in DONE is no longer a pending request.
  assign cpu_hold = cpu_req && !(state_q == DONE && owner_q == OWNER_CPU);
  assign take     = (state_q == IDLE || state_q == DONE) && gnt_valid;

  busctl_arb #(.DMA_CH(DMA_CH)) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .dma_req    (dma_req),
    .cpu_pend   (cpu_hold),
    .take       (take),
`ifdef SRAM_BUSCTL_RR_EN
    .dma_done   (state_q == DONE && owner_q != OWNER_CPU),
    .done_owner (owner_q),
`endif
    .gnt_valid  (gnt_valid),
    .gnt_owner  (gnt_owner)
  );

  // Address/direction of the access about to be launched.
  always_comb begin
    // Write-protected pages fall through to the unpaged map on writes.
    cpu_paged = page_en && (cpu_addr[ADDR_W-1 -: 3] == PAGE_WIN_BASE) && !(page_wp && !cpu_rw);
    if (cpu_paged) begin
      cpu_ext_ad = EXT_AW'({1'b1, page_sel, cpu_addr[PAGE_OFS_W-1:0]});
    end else begin
      cpu_ext_ad = EXT_AW'({1'b0, cpu_addr});
    end
    dma_ext_ad = dma_addr[0 +: EXT_AW];
    for (int i = 0; i < DMA_CH; i++) begin
      if (gnt_owner == OWNER_W'(i)) begin
        dma_ext_ad = dma_addr[i*EXT_AW +: EXT_AW];
      end else begin
        dma_ext_ad = dma_ext_ad;
      end
    end
    if (gnt_owner == OWNER_CPU) begin
      launch_ad = cpu_ext_ad;
      launch_rw = cpu_rw;
    end else begin
      launch_ad = dma_ext_ad;
      launch_rw = 1'b1;
    end
  end

  // Sequencer next state; outputs are computed for the state being entered.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rw_d        = rw_q;
    wait_d      = wait_q;
    ext_ad_d    = ext_ad_q;
    ext_dq_o_d  = ext_dq_o_q;
    ext_dq_oe_d = ext_dq_oe_q;
    ext_cs_d    = ext_cs_q;
    ext_we_n_d  = ext_we_n_q;
    ext_oe_n_d  = ext_oe_n_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    dma_ack_d   = '0;
    case (state_q)
      IDLE, DONE: begin
        ext_we_n_d = 1'b1;
        ext_oe_n_d = 1'b1;
        if (take) begin
          state_d     = SETUP;
          owner_d     = gnt_owner;
          rw_d        = launch_rw;
          ext_ad_d    = launch_ad;
          ext_cs_d    = 1'b1;
          ext_dq_oe_d = !launch_rw;
          if (!launch_rw) begin
            ext_dq_o_d = cpu_wdata;
          end else begin
            ext_dq_o_d = ext_dq_o_q;
          end
        end else begin
          state_d     = IDLE;
          ext_cs_d    = 1'b0;
          ext_dq_oe_d = 1'b0;
        end
      end
      SETUP: begin
        state_d    = STROBE;
        wait_d     = 3'(WAIT_STATES);
        ext_oe_n_d = !rw_q;
        ext_we_n_d = rw_q;
      end
      STROBE: begin
        if (wait_q == 3'd0) begin
          state_d    = DONE;
          ext_we_n_d = 1'b1;
          ext_oe_n_d = 1'b1;
          if (owner_q == OWNER_CPU) begin
            if (rw_q) begin
              cpu_rdata_d = ext_dq_i;
            end else begin
              cpu_rdata_d = cpu_rdata_q;
            end
          end else begin
            dma_rdata_d = ext_dq_i;
            for (int i = 0; i < DMA_CH; i++) begin
              dma_ack_d[i] = (owner_q == OWNER_W'(i));
            end
          end
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      default: begin
        state_d     = IDLE;
        ext_cs_d    = 1'b0;
        ext_we_n_d  = 1'b1;
        ext_oe_n_d  = 1'b1;
        ext_dq_oe_d = 1'b0;
      end
    endcase
  end

  // Sequencer and output registers; reset drops strobes and the data pad at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rw_q        <= 1'b1;
      wait_q      <= 3'd0;
      ext_ad_q    <= '0;
      ext_dq_o_q  <= 8'h00;
      ext_dq_oe_q <= 1'b0;
      ext_cs_q    <= 1'b0;
      ext_we_n_q  <= 1'b1;
      ext_oe_n_q  <= 1'b1;
      cpu_rdata_q <= 8'h00;
      dma_rdata_q <= 8'h00;
      dma_ack_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rw_q        <= rw_d;
      wait_q      <= wait_d;
      ext_ad_q    <= ext_ad_d;
      ext_dq_o_q  <= ext_dq_o_d;
      ext_dq_oe_q <= ext_dq_oe_d;
      ext_cs_q    <= ext_cs_d;
      ext_we_n_q  <= ext_we_n_d;
      ext_oe_n_q  <= ext_oe_n_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      dma_ack_q   <= dma_ack_d;
    end
  end

  assign ext_ad    = ext_ad_q;
  assign ext_dq_o  = ext_dq_o_q;
  assign ext_dq_oe = ext_dq_oe_q;
  assign ext_cs    = ext_cs_q;
  assign ext_we_n  = ext_we_n_q;
  assign ext_oe_n  = ext_oe_n_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign dma_ack   = dma_ack_q;

endmodule

// File: tb/tb_sram_busctl.sv
// Directed bench for sram_busctl with a scoreboard of expected completions.
module tb_sram_busctl;

  localparam int ADDR_W = 16;
  localparam int EXT_AW = 17;
  localparam int DMA_CH = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     cpu_req, cpu_rw;
  logic [ADDR_W-1:0]        cpu_addr;
  logic [7:0]               cpu_wdata, cpu_rdata;
  logic                     cpu_hold;
  logic                     page_en, page_wp;
  logic [2:0]               page_sel;
  logic [DMA_CH-1:0]        dma_req, dma_ack;
  logic [DMA_CH*EXT_AW-1:0] dma_addr;
  logic [7:0]               dma_rdata;
  logic [EXT_AW-1:0]        ext_ad;
  logic [7:0]               ext_dq_i, ext_dq_o;
  logic                     ext_dq_oe, ext_cs, ext_we_n, ext_oe_n;

  logic [EXT_AW-1:0]        wr_ad;
  logic [7:0]               wr_dat;

  typedef struct {
    logic       is_cpu;
    int         ch;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  sram_busctl #(.ADDR_W(ADDR_W), .EXT_AW(EXT_AW), .DMA_CH(DMA_CH),
                .WAIT_STATES(2), .PAGE_BITS(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
    .page_en(page_en), .page_wp(page_wp), .page_sel(page_sel),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .ext_ad(ext_ad), .ext_dq_i(ext_dq_i), .ext_dq_o(ext_dq_o), .ext_dq_oe(ext_dq_oe),
    .ext_cs(ext_cs), .ext_we_n(ext_we_n), .ext_oe_n(ext_oe_n)
  );

  always #5 clk = ~clk;

  // SRAM model: fixed contents at the addresses the bench uses.
  function automatic logic [7:0] sram_val(input logic [EXT_AW-1:0] a);
    case (a)
      17'h00123: return 8'h5A;
      17'h00200: return 8'h11;
      17'h10300: return 8'h22;
      default:   return 8'hEE;
    endcase
  endfunction

  assign ext_dq_i = ext_oe_n ? 8'h00 : sram_val(ext_ad);

  always @(posedge clk) begin
    if (!ext_we_n) begin
      wr_ad  <= ext_ad;
      wr_dat <= ext_dq_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int ack_ch(input logic [DMA_CH-1:0] a);
    for (int i = 0; i < DMA_CH; i++) if (a[i]) return i;
    return -1;
  endfunction

  task automatic sb_check(input logic is_cpu, input int ch, input logic [7:0] data);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_unexpected_completion", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("sb_is_cpu", {31'd0, is_cpu}, {31'd0, e.is_cpu});
      chk("sb_channel", ch, e.ch);
      chk("sb_data", {24'd0, data}, {24'd0, e.data});
    end
  endtask

  task automatic cpu_access(input logic rw, input logic [15:0] addr, input logic [7:0] wdata,
                            input logic [16:0] exp_ad, input logic [7:0] exp_rd);
    int hold_n = 0, oe_n = 0, we_n = 0, dqoe_n = 0;
    logic done = 1'b0;
    logic [16:0] seen_ad = '0;
    if (rw) sb.push_back('{1'b1, 0, exp_rd});
    @(negedge clk);
    cpu_req = 1'b1; cpu_rw = rw; cpu_addr = addr; cpu_wdata = wdata;
    #1;
    for (int cyc = 0; cyc < 50 && !done; cyc++) begin
      if (cpu_hold) hold_n++;
      if (!ext_oe_n) oe_n++;
      if (!ext_we_n) we_n++;
      if (ext_dq_oe) dqoe_n++;
      if (ext_cs) seen_ad = ext_ad;
      if (!cpu_hold) begin
        done = 1'b1;
        if (rw) sb_check(1'b1, 0, cpu_rdata);
      end else begin
        @(negedge clk); #1;
      end
    end
    chk("cpu_done_reached", {31'd0, done}, 32'd1);
    cpu_req = 1'b0;
    chk("cpu_hold_cycles", hold_n, 5);
    chk("oe_low_cycles", oe_n, rw ? 3 : 0);
    chk("we_low_cycles", we_n, rw ? 0 : 3);
    chk("dq_oe_cycles", dqoe_n, rw ? 0 : 5);
    chk("ext_ad", {15'd0, seen_ad}, {15'd0, exp_ad});
    @(negedge clk); #1;
    chk("idle_cs", {31'd0, ext_cs}, 32'd0);
    chk("idle_dq_oe", {31'd0, ext_dq_oe}, 32'd0);
    if (!rw) begin
      chk("wr_addr", {15'd0, wr_ad}, {15'd0, exp_ad});
      chk("wr_data", {24'd0, wr_dat}, {24'd0, wdata});
    end
  endtask

  initial begin
    int acks, gap, events, slots, cpu_slot;
    logic started, found;
    rst_n = 1'b0; cpu_req = 1'b0; cpu_rw = 1'b1; cpu_addr = '0; cpu_wdata = '0;
    page_en = 1'b0; page_wp = 1'b0; page_sel = 3'd0; dma_req = '0;
    dma_addr = {17'h10300, 17'h00200};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_cs", {31'd0, ext_cs}, 32'd0);
    chk("rst_we_n", {31'd0, ext_we_n}, 32'd1);
    chk("rst_oe_n", {31'd0, ext_oe_n}, 32'd1);
    chk("rst_dq_oe", {31'd0, ext_dq_oe}, 32'd0);
    chk("rst_ext_ad", {15'd0, ext_ad}, 32'd0);
    chk("rst_cpu_rdata", {24'd0, cpu_rdata}, 32'd0);
    chk("rst_dma_ack", {30'd0, dma_ack}, 32'd0);
    rst_n = 1'b1;

    // CPU read, paged write, write-protected write
    cpu_access(1'b1, 16'h0123, 8'h00, 17'h00123, 8'h5A);
    page_en = 1'b1; page_sel = 3'd5;
    cpu_access(1'b0, 16'hC010, 8'h77, 17'h1A010, 8'h00);
    page_wp = 1'b1;
    cpu_access(1'b0, 16'hC010, 8'h66, 17'h0C010, 8'h00);
    page_en = 1'b0; page_wp = 1'b0;

    // Both DMA channels held, then only channel 1
`ifdef SRAM_BUSCTL_RR_EN
    sb.push_back('{1'b0, 0, 8'h11}); sb.push_back('{1'b0, 1, 8'h22});
    sb.push_back('{1'b0, 0, 8'h11}); sb.push_back('{1'b0, 1, 8'h22});
`else
    for (int k = 0; k < 4; k++) sb.push_back('{1'b0, 0, 8'h11});
`endif
    sb.push_back('{1'b0, 1, 8'h22});
    @(negedge clk);
    dma_req = 2'b11;
    #1;
    acks = 0; gap = 0; started = 1'b0;
    for (int cyc = 0; cyc < 100 && acks < 5; cyc++) begin
      if (ext_cs) started = 1'b1;
      else if (started) gap++;
      if (dma_ack != '0) begin
        chk("ack_onehot", {31'd0, $onehot(dma_ack)}, 32'd1);
        sb_check(1'b0, ack_ch(dma_ack), dma_rdata);
        acks++;
        if (acks == 4) dma_req = 2'b10;
        else if (acks == 5) dma_req = 2'b00;
      end
      @(negedge clk); #1;
    end
    dma_req = 2'b00;
    chk("dma_ack_count", acks, 5);
    chk("dma_no_idle_gap", gap, 0);
    repeat (2) @(negedge clk);

    // Simultaneous CPU and DMA request: DMA first, then CPU
    sb.push_back('{1'b0, 0, 8'h11});
    sb.push_back('{1'b1, 0, 8'h5A});
    sb.push_back('{1'b0, 0, 8'h11});
    @(negedge clk);
    dma_req = 2'b01; cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0123;
    #1;
    events = 0; slots = 0; cpu_slot = 0; gap = 0; started = 1'b0;
    for (int cyc = 0; cyc < 100 && events < 3; cyc++) begin
      if (ext_cs) started = 1'b1;
      else if (started) gap++;
      if (dma_ack != '0) begin
        slots++; events++;
        sb_check(1'b0, ack_ch(dma_ack), dma_rdata);
        if (events == 3) dma_req = 2'b00;
      end
      if (cpu_req && !cpu_hold) begin
        slots++; events++;
        cpu_slot = slots;
        sb_check(1'b1, 0, cpu_rdata);
        cpu_req = 1'b0;
      end
      @(negedge clk); #1;
    end
    cpu_req = 1'b0; dma_req = 2'b00;
    chk("starve_events", events, 3);
    chk("cpu_slot", cpu_slot, 2);
    chk("starve_no_idle_gap", gap, 0);
    repeat (2) @(negedge clk);

    // Reset during the strobe of a write
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h0040; cpu_wdata = 8'h99;
    #1;
    found = 1'b0;
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      if (!ext_we_n) found = 1'b1;
      else begin @(negedge clk); #1; end
    end
    chk("we_strobe_seen", {31'd0, found}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we_n", {31'd0, ext_we_n}, 32'd1);
    chk("arst_cs", {31'd0, ext_cs}, 32'd0);
    chk("arst_dq_oe", {31'd0, ext_dq_oe}, 32'd0);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_oe_n", {31'd0, ext_oe_n}, 32'd1);
    chk("post_rst_ext_ad", {15'd0, ext_ad}, 32'd0);
    chk("post_rst_dq_o", {24'd0, ext_dq_o}, 32'd0);
    chk("post_rst_cpu_rdata", {24'd0, cpu_rdata}, 32'd0);
    chk("post_rst_dma_rdata", {24'd0, dma_rdata}, 32'd0);
    chk("post_rst_hold", {31'd0, cpu_hold}, 32'd0);
    @(negedge clk); #1;
    chk("post_rst_idle_cs", {31'd0, ext_cs}, 32'd0);

    // Controller works again from IDLE after reset
    cpu_access(1'b1, 16'h0123, 8'h00, 17'h00123, 8'h5A);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
